// File: rtl/xlat_queue_if.sv
// xlat_queue_if: bundles the host push port, the sequencer output port, the table
// write port, flush and status for xlat_queue.
// Optional macro XLAT_LEVEL_EN adds the 'level' status signal.
interface xlat_queue_if #(
  parameter int unsigned CODE_W = 6,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned LvlW = $clog2(DEPTH) + 1;

  // Host push port
  logic              in_valid;
  logic [CODE_W-1:0] in_code;
  logic              in_ready;
  // Sequencer output port
  logic              out_valid;
  logic [CODE_W-1:0] out_code;
  logic [ADDR_W-1:0] out_addr;
  logic              out_ready;
  // Table write port
  logic              tbl_we;
  logic [CODE_W-1:0] tbl_idx;
  logic [ADDR_W-1:0] tbl_data;
  // Control and status
  logic              flush;
  logic              busy;
`ifdef XLAT_LEVEL_EN
  logic [LvlW-1:0]   level;
`endif

  // Host/sequencer side
  modport master (
    output in_valid, in_code, out_ready, tbl_we, tbl_idx, tbl_data, flush,
    input  in_ready, out_valid, out_code, out_addr, busy
`ifdef XLAT_LEVEL_EN
    , input level
`endif
  );

  // Queue side
  modport slave (
    input  in_valid, in_code, out_ready, tbl_we, tbl_idx, tbl_data, flush,
    output in_ready, out_valid, out_code, out_addr, busy
`ifdef XLAT_LEVEL_EN
    , output level
`endif
  );
endinterface

// File: rtl/xlat_queue.sv
// xlat_queue: allophone code FIFO followed by a run-time-loadable code->ROM address
// table and a registered valid/ready output stage.
// Optional macro XLAT_LEVEL_EN exposes the registered FIFO count on bus.level.
module xlat_queue #(
  parameter int unsigned CODE_W = 6,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 4
) (
  input logic         clk,
  input logic         rst,
  xlat_queue_if.slave bus
);
  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam int unsigned TblDepth = 2 ** CODE_W;

  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [CODE_W-1:0] fifo_q [DEPTH];
  logic [ADDR_W-1:0] tbl_q  [TblDepth];

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic              out_valid_q, out_valid_d;
  logic [CODE_W-1:0] out_code_q, out_code_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;

  logic              full, empty, push, pop;
  logic [CODE_W-1:0] head_code;

  // Handshake decode; flush suppresses both push and pop on its edge.
  always_comb begin
    full      = (count_q == CntFull);
    empty     = (count_q == '0);
    push      = bus.in_valid & ~full & ~bus.flush;
    pop       = ~empty & (~out_valid_q | bus.out_ready) & ~bus.flush;
    head_code = fifo_q[rd_ptr_q];
  end

  // Pointer and count next-state; power-of-two depth makes pointer wrap implicit.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      case ({push, pop})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  // Output stage next-state; the table read uses the registered (pre-write) entry.
  always_comb begin
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_addr_d  = out_addr_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (pop) begin
      out_valid_d = 1'b1;
      out_code_d  = head_code;
      out_addr_d  = tbl_q[head_code];
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control and output-stage state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_addr_q  <= out_addr_d;
    end
  end

  // FIFO storage; contents are don't-care outside [rd_ptr, wr_ptr), so no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus.in_code;
  end

  // Translation table; writes are independent of flush and the data path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TblDepth; i++) tbl_q[i] <= '0;
    end else if (bus.tbl_we) begin
      tbl_q[bus.tbl_idx] <= bus.tbl_data;
    end
  end

  // Status and output drive.
  always_comb begin
    bus.in_ready  = ~full;
    bus.busy      = out_valid_q | ~empty;
    bus.out_valid = out_valid_q;
    bus.out_code  = out_code_q;
    bus.out_addr  = out_addr_q;
  end

`ifdef XLAT_LEVEL_EN
  assign bus.level = count_q;
`endif

endmodule

// File: tb/tb_xlat_queue.sv
// tb_xlat_queue: directed bench for xlat_queue (DEPTH=4). Checks level too when
// compiled with XLAT_LEVEL_EN.
module tb_xlat_queue;
  localparam int unsigned CODE_W = 6;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 4;

  logic clk;
  logic rst;

  int unsigned n_checks;
  int unsigned n_pass;

  logic [ADDR_W-1:0] tbl_m [64];

  xlat_queue_if #(.CODE_W(CODE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  xlat_queue #(.CODE_W(CODE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tbl_write(input int unsigned idx, input int unsigned data);
    bus.tbl_we   = 1'b1;
    bus.tbl_idx  = CODE_W'(idx);
    bus.tbl_data = ADDR_W'(data);
    tick();
    bus.tbl_we   = 1'b0;
    tbl_m[idx]   = ADDR_W'(data);
  endtask

  task automatic push(input int unsigned code);
    bus.in_valid = 1'b1;
    bus.in_code  = CODE_W'(code);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_level(input string tag, input int unsigned exp);
`ifdef XLAT_LEVEL_EN
    check(tag, 32'(bus.level), exp);
`else
    if (exp > DEPTH) $display("bad level expectation %s", tag);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 64; i++) tbl_m[i] = '0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_code  = '0;
    bus.out_ready = 1'b0;
    bus.tbl_we   = 1'b0;
    bus.tbl_idx  = '0;
    bus.tbl_data = '0;
    bus.flush    = 1'b0;

    // Reset state
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_code", 32'(bus.out_code), 0);
    check("rst_out_addr", 32'(bus.out_addr), 0);
    check_level("rst_level", 0);
    tick();
    tick();
    rst = 1'b0;

    // Table load then single code
    tbl_write(5, 'h123);
    tbl_write(6, 'h040);
    bus.out_ready = 1'b1;
    push(5);
    check("lat_n_valid", 32'(bus.out_valid), 0);
    check("lat_n_busy", 32'(bus.busy), 1);
    tick();
    check("lat_n1_valid", 32'(bus.out_valid), 1);
    check("lat_n1_code", 32'(bus.out_code), 5);
    check("lat_n1_addr", 32'(bus.out_addr), 'h123);
    check("lat_n1_busy", 32'(bus.busy), 1);
    tick();
    check("lat_drain_valid", 32'(bus.out_valid), 0);
    check("lat_drain_busy", 32'(bus.busy), 0);
    check("lat_hold_code", 32'(bus.out_code), 5);

    // Fill to full with output stalled
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_code  = CODE_W'(i);
      tick();
      if (i == 4) check("fill4_in_ready", 32'(bus.in_ready), 1);
      if (i == 5) check("fill5_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    check("full_in_ready", 32'(bus.in_ready), 0);
    check("full_out_code", 32'(bus.out_code), 1);
    check_level("full_level", 4);
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("drain%0d_valid", k), 32'(bus.out_valid), 1);
      check($sformatf("drain%0d_code", k), 32'(bus.out_code), 32'(k));
      tick();
    end
    check("drain_end_valid", 32'(bus.out_valid), 0);
    check("drain_end_busy", 32'(bus.busy), 0);
    check_level("drain_end_level", 0);

    // Back-to-back streaming with distinct table entries
    for (int i = 0; i < 16; i++) tbl_write(32'(i + 16), 32'('h200 + i * 5));
    for (int i = 0; i <= 16; i++) begin
      bus.in_valid = (i < 16);
      bus.in_code  = CODE_W'(i + 16);
      tick();
      if (i >= 1) begin
        check($sformatf("strm%0d_valid", i - 1), 32'(bus.out_valid), 1);
        check($sformatf("strm%0d_code", i - 1), 32'(bus.out_code), 32'(i + 15));
        check($sformatf("strm%0d_addr", i - 1), 32'(bus.out_addr), 32'(tbl_m[i + 15]));
      end
    end
    bus.in_valid = 1'b0;
    tick();
    check("strm_end_valid", 32'(bus.out_valid), 0);

    // Output backpressure: code 5 presented, code 6 waiting
    bus.out_ready = 1'b0;
    push(5);
    push(6);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("bp%0d_valid", c), 32'(bus.out_valid), 1);
      check($sformatf("bp%0d_code", c), 32'(bus.out_code), 5);
      check($sformatf("bp%0d_addr", c), 32'(bus.out_addr), 'h123);
      check_level($sformatf("bp%0d_level", c), 1);
    end

    // Same-edge table write on the edge that pops code 6
    bus.out_ready = 1'b1;
    bus.tbl_we   = 1'b1;
    bus.tbl_idx  = CODE_W'(6);
    bus.tbl_data = ADDR_W'('h3FF);
    tick();
    bus.tbl_we   = 1'b0;
    tbl_m[6]     = 'h3FF;
    check("sew_code", 32'(bus.out_code), 6);
    check("sew_addr_old", 32'(bus.out_addr), 'h040);
    tick();
    check("sew_drain_valid", 32'(bus.out_valid), 0);
    push(6);
    tick();
    check("sew_addr_new", 32'(bus.out_addr), 'h3FF);
    tick();

    // Flush with 3 queued entries and a concurrent push
    bus.out_ready = 1'b0;
    push(1);
    push(2);
    push(3);
    push(4);
    check_level("preflush_level", 3);
    check("preflush_code", 32'(bus.out_code), 1);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_code  = CODE_W'(7);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_valid", 32'(bus.out_valid), 0);
    check("flush_busy", 32'(bus.busy), 0);
    check("flush_in_ready", 32'(bus.in_ready), 1);
    check("flush_code_kept", 32'(bus.out_code), 1);
    check_level("flush_level", 0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("flush_dropped", 32'(bus.out_valid), 0);
    push(5);
    tick();
    check("flush_tbl_valid", 32'(bus.out_valid), 1);
    check("flush_tbl_addr", 32'(bus.out_addr), 'h123);
    tick();

    // Asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    push(6);
    push(5);
    check("prerst_valid", 32'(bus.out_valid), 1);
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus.out_valid), 0);
    check("arst_code", 32'(bus.out_code), 0);
    check("arst_addr", 32'(bus.out_addr), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_in_ready", 32'(bus.in_ready), 1);
    check_level("arst_level", 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) tbl_m[i] = '0;
    bus.out_ready = 1'b1;
    push(5);
    tick();
    check("postrst_valid", 32'(bus.out_valid), 1);
    check("postrst_code", 32'(bus.out_code), 5);
    check("postrst_tbl5", 32'(bus.out_addr), 32'(tbl_m[5]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
